// File: rtl/cfu_sbuf_pkg.sv
// Shared types and default sizing for the stream buffer.
// The replay state enum is used only when CFU_SBUF_REPLAY_EN is defined.
package cfu_sbuf_pkg;

  localparam int SBUF_DATA_W = 32;
  localparam int SBUF_DEPTH  = 256;

  typedef enum logic {
    IDLE   = 1'b0,
    RETAIN = 1'b1
  } sbuf_state_e;

endpackage

// File: rtl/cfu_sbuf_mem.sv
// Storage array for the stream buffer: one synchronous write port and one
// asynchronous read port. There is no reset, so contents start undefined.
module cfu_sbuf_mem
  import cfu_sbuf_pkg::*;
#(
  parameter int DATA_W = SBUF_DATA_W,
  parameter int DEPTH  = SBUF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cfu_stream_buffer.sv
// First-word-fall-through stream FIFO with optional mark/rewind/release replay.
// Replay logic is built only when CFU_SBUF_REPLAY_EN is defined.
module cfu_stream_buffer
  import cfu_sbuf_pkg::*;
#(
  parameter int DATA_W    = SBUF_DATA_W,
  parameter int DEPTH     = SBUF_DEPTH,
  parameter int AFULL_LVL = DEPTH - 4,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              write_en,
  input  logic [DATA_W-1:0] write_data,
  output logic              write_full,
  output logic              write_afull,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              read_data_valid,
  output logic              read_empty,
  input  logic              mark,
  input  logic              rewind,
  input  logic              release_i,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     used,
  output logic              overflow,
  output logic              underflow
);

  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              push, pop, pop_req;
  logic [DATA_W-1:0] mem_rdata;

  // Full/empty come from registered state only, so a same-edge pop never frees room for a push.
  assign write_full  = (used == CW'(DEPTH));
  assign write_afull = (used >= CW'(AFULL_LVL));
  assign read_empty  = (count_q == '0);
  assign push        = write_en & ~write_full;
  assign pop_req     = read_en & ~read_empty;

`ifdef CFU_SBUF_REPLAY_EN
  sbuf_state_e   state_q, state_d;
  logic [AW-1:0] mk_q, mk_d;
  logic [CW-1:0] used_q, used_d;
  logic          rw_eff, rl_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mk_q    <= '0;
      used_q  <= '0;
    end else begin
      state_q <= state_d;
      mk_q    <= mk_d;
      used_q  <= used_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear)       state_d = IDLE;
    else if (rw_eff) state_d = RETAIN;
    else if (rl_eff) state_d = IDLE;
    else if (mark)   state_d = RETAIN;
  end

  // Rewind and release only mean something while entries are being retained.
  always_comb begin
    rw_eff = rewind & (state_q == RETAIN);
    rl_eff = release_i & (state_q == RETAIN);
  end

  assign pop  = pop_req & ~rw_eff;
  assign used = used_q;
`else
  logic unused_replay;
  assign unused_replay = ^{mark, rewind, release_i};
  assign pop  = pop_req;
  assign used = count_q;
`endif

  always_comb begin
    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
    ovf_d   = ovf_q | (write_en & write_full);
    unf_d   = unf_q | (read_en & read_empty);
`ifdef CFU_SBUF_REPLAY_EN
    mk_d   = mk_q;
    used_d = (state_q == IDLE) ? count_d : used_q + CW'(push);
    if (rw_eff) begin
      rd_d    = mk_q;
      count_d = used_q + CW'(push);
      used_d  = count_d;
    end else if (rl_eff || mark) begin
      // Entries behind the post-pop head are freed; retention restarts there or ends.
      mk_d   = rd_d;
      used_d = count_d;
    end
`endif
    if (clear) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
`ifdef CFU_SBUF_REPLAY_EN
      mk_d    = '0;
      used_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  cfu_sbuf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push & ~clear),
    .waddr_i (wr_q),
    .wdata_i (write_data),
    .raddr_i (rd_q),
    .rdata_o (mem_rdata)
  );

  assign read_data_valid = ~read_empty;
  assign read_data       = read_empty ? '0 : mem_rdata;
  assign count           = count_q;
  assign overflow        = ovf_q;
  assign underflow       = unf_q;

endmodule
